// File: rtl/seg_display_pkg.sv
// ============================================================================
// Module  : seg_display_pkg
// Brief   : Shared FSM state type, glyph table and sizing helpers for the
//           multiplexed seven-segment display controller.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package seg_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Active-low glyphs, bit0 = a .. bit6 = g; b and d are lowercase forms.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'h7F;

    function automatic int bcd_digits(input int value_w);
        return (value_w * 31) / 100 + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module  : bin2bcd_seq
// Brief   : Sequential binary-to-BCD (double dabble) / hex-nibble converter
//           with start/busy/done handshake.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import seg_display_pkg::*;
#(
    parameter int VALUE_W    = 16,
    parameter int BCD_DIGITS = bcd_digits(VALUE_W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic                    i_hex,
    input  logic [VALUE_W-1:0]      i_value,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [BCD_DIGITS*4-1:0] o_digits
);

    localparam int BCD_W = BCD_DIGITS * 4;
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(VALUE_W - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [VALUE_W-1:0] r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [CNT_W-1:0]   r_step;
    logic               r_hex;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = SHIFT;
            SHIFT:   if (r_hex || (r_step == LAST_STEP)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state != IDLE);
        o_done = (r_state == DONE);
    end

    // Add-3 correction applied to every BCD digit before each shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (r_bcd[d*4 +: 4] >= 4'd5) begin
                w_bcd_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_step <= '0;
            r_hex  <= 1'b0;
        end else if ((r_state == IDLE) && i_start) begin
            r_bin  <= i_value;
            r_bcd  <= '0;
            r_step <= '0;
            r_hex  <= i_hex;
        end else if (r_state == SHIFT) begin
            if (r_hex) begin
                r_bcd <= BCD_W'(r_bin);
            end else begin
                r_bcd  <= {w_bcd_adj[BCD_W-2:0], r_bin[VALUE_W-1]};
                r_bin  <= {r_bin[VALUE_W-2:0], 1'b0};
                r_step <= r_step + CNT_W'(1);
            end
        end
    end

    assign o_digits = r_bcd;

endmodule

`default_nettype wire

// File: rtl/segment_display_ctrl.sv
// ============================================================================
// Module  : segment_display_ctrl
// Brief   : Multiplexed seven-segment controller with decimal/hex conversion.
//           Optional macro LEADING_ZERO_BLANK_EN blanks decimal leading zeros.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module segment_display_ctrl
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_W     = 16,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  fpga_clk1,
    input  logic                  reset,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic [NUM_DIGITS-1:0] dp_sel,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  busy,
    output logic                  overflow
);

    localparam int BCD_DIGITS = bcd_digits(VALUE_W);
    localparam int DIV_W      = $clog2(REFRESH_DIV);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    w_busy;
    logic                    w_done;
    logic                    w_start;
    logic [BCD_DIGITS*4-1:0] w_bcd;
    logic                    r_hex_cap;
    logic [NUM_DIGITS-1:0]   r_dp_cap;

    assign w_start = load & ~w_busy;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_conv (
        .clk      (fpga_clk1),
        .rst      (reset),
        .i_start  (w_start),
        .i_hex    (hex_mode),
        .i_value  (value),
        .o_busy   (w_busy),
        .o_done   (w_done),
        .o_digits (w_bcd)
    );

    always_ff @(posedge fpga_clk1 or posedge reset) begin
        if (reset) begin
            r_hex_cap <= 1'b0;
            r_dp_cap  <= '0;
        end else if (w_start) begin
            r_hex_cap <= hex_mode;
            r_dp_cap  <= dp_sel;
        end
    end

    logic [3:0]            w_dig [NUM_DIGITS];
    logic                  w_hi_nz;
    logic                  w_ovf;
    logic [NUM_DIGITS-1:0] w_blank;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        if (g < BCD_DIGITS) begin : g_src
            assign w_dig[g] = w_bcd[g*4 +: 4];
        end else begin : g_zero
            assign w_dig[g] = 4'd0;
        end
    end

    if (BCD_DIGITS > NUM_DIGITS) begin : g_ovf
        assign w_hi_nz = |w_bcd[BCD_DIGITS*4-1:NUM_DIGITS*4];
    end else begin : g_no_ovf
        assign w_hi_nz = 1'b0;
    end

    assign w_ovf = ~r_hex_cap & w_hi_nz;

`ifdef LEADING_ZERO_BLANK_EN
    logic w_lz_run;
    // Walk down from the top digit; digit 0 is never blanked.
    always_comb begin
        w_blank  = '0;
        w_lz_run = ~r_hex_cap;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_lz_run   = w_lz_run & (w_dig[i] == 4'd0);
            w_blank[i] = w_lz_run;
        end
    end
`else
    assign w_blank = '0;
`endif

    logic [3:0]            r_dig [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_blank;
    logic [NUM_DIGITS-1:0] r_dpen;
    logic                  r_ovf;

    always_ff @(posedge fpga_clk1 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_dig[i] <= 4'd0;
            r_blank <= '0;
            r_dpen  <= '0;
            r_ovf   <= 1'b0;
        end else if (w_done) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_dig[i] <= w_dig[i];
            r_blank <= w_blank;
            r_dpen  <= r_dp_cap;
            r_ovf   <= w_ovf;
        end
    end

    logic [DIV_W-1:0]      r_div;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_active;
    logic                  w_wrap;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_active_nxt;
    logic [6:0]            w_glyph;
    logic                  w_dp_n;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;

    assign w_wrap       = (r_div == DIV_W'(REFRESH_DIV - 1));
    assign w_active_nxt = r_active | w_wrap;

    // The first wrap after reset lights digit 0 rather than advancing past it.
    always_comb begin
        w_idx_nxt = r_idx;
        if (w_wrap && r_active) begin
            w_idx_nxt = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end
    end

    always_comb begin
        if (r_ovf) begin
            w_glyph = DASH;
        end else if (r_blank[w_idx_nxt]) begin
            w_glyph = BLANK;
        end else begin
            w_glyph = GLYPH_TABLE[r_dig[w_idx_nxt]];
        end
        w_dp_n = ~(r_dpen[w_idx_nxt] & ~r_blank[w_idx_nxt] & ~r_ovf);
    end

    always_ff @(posedge fpga_clk1 or posedge reset) begin
        if (reset) begin
            r_div    <= '0;
            r_idx    <= '0;
            r_active <= 1'b0;
            r_an     <= '1;
            r_seg    <= BLANK;
            r_dp     <= 1'b1;
        end else begin
            r_div    <= w_wrap ? '0 : r_div + DIV_W'(1);
            r_idx    <= w_idx_nxt;
            r_active <= w_active_nxt;
            if (w_active_nxt) begin
                r_an  <= ~(NUM_DIGITS'(1) << w_idx_nxt);
                r_seg <= w_glyph;
                r_dp  <= w_dp_n;
            end
        end
    end

    assign seg      = r_seg;
    assign dp       = r_dp;
    assign an       = r_an;
    assign busy     = w_busy;
    assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_segment_display_ctrl.sv
// ============================================================================
// Module  : tb_segment_display_ctrl
// Brief   : Self-checking bench for segment_display_ctrl (4 digits, 16-bit,
//           refresh divide 4); honours LEADING_ZERO_BLANK_EN when defined.
// Rev     : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_segment_display_ctrl;

    localparam int ND = 4;
    localparam int VW = 16;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [VW-1:0] value = '0;
    logic          load = 1'b0;
    logic          hex_mode = 1'b0;
    logic [ND-1:0] dp_sel = '0;
    logic [6:0]    seg;
    logic          dp;
    logic [ND-1:0] an;
    logic          busy;
    logic          overflow;

    always #5 clk = ~clk;

    segment_display_ctrl #(
        .NUM_DIGITS  (ND),
        .VALUE_W     (VW),
        .REFRESH_DIV (RD)
    ) dut (
        .fpga_clk1 (clk),
        .reset     (rst),
        .value     (value),
        .load      (load),
        .hex_mode  (hex_mode),
        .dp_sel    (dp_sel),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .busy      (busy),
        .overflow  (overflow)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the number currently shown and how it was loaded.
    int      m_val     = 0;
    bit      m_hex     = 1'b0;
    bit [ND-1:0] m_dp  = '0;
    bit      m_noblank = 1'b1;

    string GL [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] glyph(string s);
        logic [6:0] g = 7'h7F;
        for (int k = 0; k < s.len(); k++) g[int'(s[k]) - 97] = 1'b0;
        return g;
    endfunction

    function automatic int pow10(int n);
        int p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    function automatic bit exp_ovf();
        return !m_hex && (m_val >= pow10(ND));
    endfunction

    function automatic bit exp_blank(int idx);
`ifdef LEADING_ZERO_BLANK_EN
        return !m_hex && !m_noblank && (idx > 0) && (m_val < pow10(idx));
`else
        return (idx < 0);
`endif
    endfunction

    function automatic logic [6:0] exp_seg(int idx);
        int d;
        if (exp_ovf()) return glyph("g");
        if (exp_blank(idx)) return 7'h7F;
        d = m_hex ? ((m_val >> (4 * idx)) & 15) : ((m_val / pow10(idx)) % 10);
        return glyph(GL[d]);
    endfunction

    function automatic logic exp_dp(int idx);
        return (m_dp[idx] && !exp_blank(idx) && !exp_ovf()) ? 1'b0 : 1'b1;
    endfunction

    function automatic int idx_of(logic [ND-1:0] a);
        for (int i = 0; i < ND; i++) if (a == ~(ND'(1) << i)) return i;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_load(int v, bit hx, logic [ND-1:0] dps);
        value    = VW'(v);
        hex_mode = hx;
        dp_sel   = dps;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic wait_idle(string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) begin
            total++;
            bad++;
            $error("FAIL %s_idle: busy stuck, observed %b expected 0", tag, busy);
        end
    endtask

    task automatic set_model(int v, bit hx, logic [ND-1:0] dps);
        m_val     = v;
        m_hex     = hx;
        m_dp      = dps;
        m_noblank = 1'b0;
    endtask

    task automatic check_digits(string tag);
        for (int i = 0; i < ND; i++) begin
            logic [ND-1:0] want;
            int n;
            want = ~(ND'(1) << i);
            n = 0;
            while (an !== want && n < 4 * RD + 4) begin
                tick();
                n++;
            end
            if (an !== want) begin
                total++;
                bad++;
                $error("FAIL %s_scan%0d: timeout, observed an=%b expected %b", tag, i, an, want);
            end else begin
                chk($sformatf("%s_seg%0d", tag, i), 32'(seg), 32'(exp_seg(i)));
                chk($sformatf("%s_dp%0d", tag, i), 32'(dp), 32'(exp_dp(i)));
            end
        end
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_an"},   32'(an),       32'({ND{1'b1}}));
        chk({tag, "_seg"},  32'(seg),      32'h7F);
        chk({tag, "_dp"},   32'(dp),       32'd1);
        chk({tag, "_busy"}, 32'(busy),     32'd0);
        chk({tag, "_ovf"},  32'(overflow), 32'd0);
    endtask

    task automatic check_scan_order();
        logic [ND-1:0] seq [5];
        logic [ND-1:0] prev;
        int n = 0;
        seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111; seq[4] = 4'b1110;
        while (an !== seq[0] && n < 12) begin
            tick();
            n++;
        end
        chk("scan_first", 32'(an), 32'(seq[0]));
        prev = seq[0];
        for (int s = 1; s < 5; s++) begin
            repeat (3) tick();
            chk($sformatf("scan_hold%0d", s), 32'(an), 32'(prev));
            tick();
            chk($sformatf("scan_step%0d", s), 32'(an), 32'(seq[s]));
            prev = seq[s];
        end
    endtask

    initial begin
        int v;
        bit hx;
        logic [ND-1:0] dps;
        int ix;

        // Reset state and first scan after release
        repeat (2) tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        check_scan_order();
        check_digits("post_rst");

        // Decimal 2578: busy 17 cycles, display change visible on cycle 18
        do_load(2578, 1'b0, '0);
        chk("dec_busy0", 32'(busy), 32'd1);
        repeat (16) tick();
        chk("dec_busy16", 32'(busy), 32'd1);
        tick();
        chk("dec_busy17", 32'(busy), 32'd0);
        ix = idx_of(an);
        chk("dec_old17", 32'(seg), 32'(exp_seg(ix)));
        set_model(2578, 1'b0, '0);
        tick();
        ix = idx_of(an);
        chk("dec_new18", 32'(seg), 32'(exp_seg(ix)));
        chk("dec_ovf", 32'(overflow), 32'd0);
        check_digits("dec2578");

        // Hex ABCD with dp on digit 2, 3-cycle latency
        do_load(16'hABCD, 1'b1, 4'b0100);
        tick();
        chk("hex_busy1", 32'(busy), 32'd1);
        tick();
        chk("hex_busy2", 32'(busy), 32'd0);
        ix = idx_of(an);
        chk("hex_old2", 32'(seg), 32'(exp_seg(ix)));
        set_model(16'hABCD, 1'b1, 4'b0100);
        tick();
        ix = idx_of(an);
        chk("hex_new3", 32'(seg), 32'(exp_seg(ix)));
        chk("hex_ovf", 32'(overflow), 32'd0);
        check_digits("hexABCD");

        // Decimal overflow: dashes everywhere, dp forced off
        do_load(12345, 1'b0, 4'b1111);
        wait_idle("ovf");
        set_model(12345, 1'b0, 4'b1111);
        tick();
        chk("ovf_flag", 32'(overflow), 32'd1);
        check_digits("ovf12345");

        // Load while busy is ignored
        do_load(42, 1'b0, '0);
        repeat (4) tick();
        value = VW'(9999);
        load  = 1'b1;
        tick();
        load  = 1'b0;
        chk("ign_busy", 32'(busy), 32'd1);
        wait_idle("ign");
        set_model(42, 1'b0, '0);
        tick();
        chk("ign_ovf", 32'(overflow), 32'd0);
        check_digits("ign42");

        // Randomised loads against the model
        for (int r = 0; r < 8; r++) begin
            hx  = 1'($urandom_range(0, 1));
            v   = (r % 3 == 0) ? int'($urandom_range(0, 999)) : int'($urandom_range(0, 65535));
            dps = ND'($urandom);
            do_load(v, hx, dps);
            wait_idle($sformatf("rnd%0d", r));
            set_model(v, hx, dps);
            tick();
            chk($sformatf("rnd%0d_ovf", r), 32'(overflow), 32'(exp_ovf()));
            check_digits($sformatf("rnd%0d", r));
        end

        // Reset at cycle 8 of a conversion aborts it cleanly
        do_load(2578, 1'b0, '0);
        repeat (8) tick();
        rst = 1'b1;
        #2;
        check_reset_outputs("midrst");
        tick();
        rst = 1'b0;
        m_val = 0; m_hex = 1'b0; m_dp = '0; m_noblank = 1'b1;
        check_scan_order();
        check_digits("midrst_zero");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
